interp_block_ctrl: RTL and testbench

- Sequencer for one 8x8 sub-pixel interpolation block: row fetch into the 15-row input shift register, filter-pipeline drain, then 40 serial writes into the output filler.
- Sits between the reference-block fetch unit (row handshake), the datapath load enables, and the consumer of the 2560-bit filler output (valid/ack handshake).
- Outputs are registered on posedge clock; datapath registers sample them on negedge.

---
 rtl/interp_block_ctrl.sv | 132 +++++++++++++
 tb/tb_interp_block_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/interp_block_ctrl.sv
// Block sequencer for one 8x8 sub-pixel interpolation: row fetch, filter drain,
// serial output-filler writes, then hold until the consumer acknowledges.
module interp_block_ctrl #(
    parameter int ROWS      = 15,
    parameter int OUT_WORDS = 40,
    parameter int FILT_LAT  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  frac_x,
    input  logic [1:0]  frac_y,
    input  logic        abort,
    input  logic        row_valid,
    output logic        row_ready,
    output logic        isr_load_L,
    output logic        filt_en,
    output logic        bypass,
    output logic        of_load_L,
    output logic [7:0]  of_sel,
    output logic        out_valid,
    input  logic        out_ack,
    output logic        busy,
    output logic        done,
    output logic [15:0] stall_cnt
);
    localparam int DW = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, FILL, HOLD} state_t;

    state_t         state_q, state_d;
    logic [3:0]     row_q, row_d;
    logic [7:0]     word_q, word_d;
    logic [DW-1:0]  drain_q, drain_d;
    logic           bypass_q, bypass_d;
    logic           done_q, done_d;
    logic [15:0]    stall_q, stall_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            word_q   <= '0;
            drain_q  <= '0;
            bypass_q <= 1'b0;
            done_q   <= 1'b0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            word_q   <= word_d;
            drain_q  <= drain_d;
            bypass_q <= bypass_d;
            done_q   <= done_d;
            stall_q  <= stall_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        word_d   = word_q;
        drain_d  = drain_q;
        bypass_d = bypass_q;
        done_d   = 1'b0;
        stall_d  = stall_q;
        case (state_q)
            IDLE: if (start) begin
                bypass_d = (frac_x == 2'd0) && (frac_y == 2'd0);
                stall_d  = '0;
                row_d    = '0;
                word_d   = '0;
                drain_d  = '0;
                state_d  = LOAD;
            end
            LOAD: begin
                if (row_valid) begin
                    if (row_q == 4'(ROWS - 1)) begin
                        row_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                end else if (stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end
            end
            DRAIN: begin
                if (drain_q == DW'(FILT_LAT - 1)) begin
                    drain_d = '0;
                    state_d = FILL;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            FILL: begin
                if (word_q == 8'(OUT_WORDS - 1)) begin
                    word_d  = '0;
                    state_d = HOLD;
                end else begin
                    word_d = word_q + 8'd1;
                end
            end
            HOLD: if (out_ack) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Cancel wins over every transition; the stall count survives for debug.
        if (abort && state_q != IDLE) begin
            state_d  = IDLE;
            row_d    = '0;
            word_d   = '0;
            drain_d  = '0;
            bypass_d = 1'b0;
            done_d   = 1'b0;
            stall_d  = stall_q;
        end
    end

    assign row_ready  = (state_q == LOAD);
    assign isr_load_L = ~((state_q == LOAD) && row_valid);
    assign filt_en    = ((state_q == DRAIN) || (state_q == FILL)) && !bypass_q;
    assign bypass     = bypass_q;
    assign of_load_L  = (state_q != FILL);
    assign of_sel     = word_q;
    assign out_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign stall_cnt  = stall_q;
endmodule

// File: tb/tb_interp_block_ctrl.sv
// Directed bench for interp_block_ctrl: hand-computed timelines for nominal,
// stalled, full-pel, backpressure, abort and async-reset blocks.
module tb_interp_block_ctrl;
    logic        clock = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic        row_valid = 1'b0, out_ack = 1'b0;
    logic [1:0]  frac_x = 2'd0, frac_y = 2'd0;
    logic        row_ready, isr_load_L, filt_en, bypass, of_load_L, out_valid, busy, done;
    logic [7:0]  of_sel;
    logic [15:0] stall_cnt;
    int          n_checks = 0, n_fail = 0;

    interp_block_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .frac_x(frac_x), .frac_y(frac_y),
        .abort(abort), .row_valid(row_valid), .row_ready(row_ready), .isr_load_L(isr_load_L),
        .filt_en(filt_en), .bypass(bypass), .of_load_L(of_load_L), .of_sel(of_sel),
        .out_valid(out_valid), .out_ack(out_ack), .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Cycle 0 carries start; LOAD begins at cycle 1. Samples taken 4 time units after posedge.
    task automatic run_block(input string tag, input logic [1:0] fx, input logic [1:0] fy,
                             input logic [31:0] stalls, input int ack_wait, input int abort_at,
                             input int exp_fill, input int exp_nof, input int exp_filt,
                             input int exp_done, input int exp_ov, input int exp_stall,
                             input int exp_byp);
        int n_isr = 0, n_of = 0, n_filt = 0, n_ov = 0, first_of = -1, done_c = -1;
        start = 1'b1; frac_x = fx; frac_y = fy; row_valid = 1'b1; abort = 1'b0; out_ack = 1'b0;
        #3;
        tick();
        start = 1'b0;
        for (int c = 1; c < 300; c++) begin
            row_valid = (c < 32) ? !stalls[c] : 1'b1;
            abort     = (c == abort_at);
            out_ack   = (c >= exp_fill + 40 + ack_wait);
            #3;
            if (!isr_load_L) n_isr++;
            if (filt_en) n_filt++;
            if (out_valid) n_ov++;
            if (!of_load_L) begin
                if (first_of < 0) first_of = c;
                n_of++;
                chk({tag, ".of_sel"}, int'(of_sel), c - exp_fill);
            end
            if (done) begin
                done_c = c;
                chk({tag, ".busy_at_done"}, int'(busy), 0);
                chk({tag, ".ov_at_done"}, int'(out_valid), 0);
                chk({tag, ".sel_at_done"}, int'(of_sel), 0);
            end
            if (abort_at > 0 && c == abort_at + 1) begin
                chk({tag, ".busy_after_abort"}, int'(busy), 0);
                chk({tag, ".ofl_after_abort"}, int'(of_load_L), 1);
                chk({tag, ".sel_after_abort"}, int'(of_sel), 0);
                chk({tag, ".byp_after_abort"}, int'(bypass), 0);
            end
            if (done_c >= 0 || (abort_at > 0 && c == abort_at + 3)) break;
            tick();
        end
        abort = 1'b0; out_ack = 1'b0;
        chk({tag, ".isr_pulses"}, n_isr, 15);
        chk({tag, ".first_fill"}, first_of, exp_fill);
        chk({tag, ".of_loads"}, n_of, exp_nof);
        chk({tag, ".filt_cycles"}, n_filt, exp_filt);
        chk({tag, ".done_cycle"}, done_c, exp_done);
        chk({tag, ".ov_cycles"}, n_ov, exp_ov);
        chk({tag, ".stall_cnt"}, int'(stall_cnt), exp_stall);
        chk({tag, ".bypass"}, int'(bypass), exp_byp);
    endtask

    initial begin
        row_valid = 1'b1;
        tick(); tick();
        chk("rst.row_ready", int'(row_ready), 0);
        chk("rst.isr_load_L", int'(isr_load_L), 1);
        chk("rst.of_load_L", int'(of_load_L), 1);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.filt_en", int'(filt_en), 0);
        chk("rst.of_sel", int'(of_sel), 0);
        reset = 1'b0;
        tick();
        chk("idle.isr_ignores_rv", int'(isr_load_L), 1);

        run_block("nominal",  2'd1, 2'd2, 32'h0,    0,  0, 18, 40, 42, 59, 1,  0, 0);
        run_block("stalled",  2'd1, 2'd2, 32'h1088, 0,  0, 21, 40, 42, 62, 1,  3, 0);
        run_block("fullpel",  2'd0, 2'd0, 32'h0,    0,  0, 18, 40,  0, 59, 1,  0, 1);
        run_block("backpres", 2'd3, 2'd0, 32'h0,   10,  0, 18, 40, 42, 69, 11, 0, 0);
        run_block("abort",    2'd1, 2'd2, 32'h0,    0, 38, 18, 21, 23, -1, 0,  0, 0);
        run_block("post_abt", 2'd2, 2'd1, 32'h0,    0,  0, 18, 40, 42, 59, 1,  0, 0);

        // Async reset mid-LOAD, applied between clock edges.
        start = 1'b1; frac_x = 2'd1; frac_y = 2'd1;
        tick();
        start = 1'b0; row_valid = 1'b0;
        tick(); tick();
        row_valid = 1'b1;
        #3;
        chk("arst.pre_stall", int'(stall_cnt), 2);
        chk("arst.pre_ready", int'(row_ready), 1);
        tick();
        #2; reset = 1'b1;
        #1;
        chk("arst.row_ready", int'(row_ready), 0);
        chk("arst.isr_load_L", int'(isr_load_L), 1);
        chk("arst.busy", int'(busy), 0);
        chk("arst.stall_cnt", int'(stall_cnt), 0);
        chk("arst.bypass", int'(bypass), 0);
        tick();
        reset = 1'b0;
        tick();
        run_block("post_rst", 2'd1, 2'd2, 32'h0, 0, 0, 18, 40, 42, 59, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
